// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 8N1 by default; rx_done strobes once per frame.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICKS   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_error,
`endif
   output logic                 frame_error
);

   localparam int TW = (SB_TICKS > OVERSAMPLE) ? $clog2(SB_TICKS) : $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] C_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] C_FULL = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] C_STOP = TW'(SB_TICKS - 1);
   localparam logic [BW-1:0] C_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 r_state;
   logic [TW-1:0]          r_tick_cnt;
   logic [BW-1:0]          r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   r_rx_data;
   logic                   r_rx_done;
   logic                   r_frame_error;
   logic                   r_rx_meta;
   logic                   r_rx_s;
`ifdef UART_RX_PARITY_EN
   logic                   r_par_bit;
   logic                   r_parity_error;
`endif

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_tick_cnt     <= '0;
         r_bit_cnt      <= '0;
         r_shift        <= '0;
         r_rx_data      <= '0;
         r_rx_done      <= 1'b0;
         r_frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit      <= 1'b0;
         r_parity_error <= 1'b0;
`endif
      end else begin
         r_rx_done <= 1'b0;
         case (r_state)
            // A tick coinciding with the falling edge is deliberately not counted.
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state    <= S_START;
                  r_tick_cnt <= '0;
               end
            end
            S_START: begin
               if (tick) begin
                  if (r_tick_cnt == C_HALF) begin
                     if (!r_rx_s) begin
                        r_state    <= S_DATA;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (r_tick_cnt == C_FULL) begin
                     r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                     r_tick_cnt <= '0;
                     if (r_bit_cnt == C_LAST) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                     end else begin
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick) begin
                  if (r_tick_cnt == C_FULL) begin
                     r_par_bit  <= r_rx_s;
                     r_tick_cnt <= '0;
                     r_state    <= S_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end
`endif
            // Stop sampled low means a framing error; a line still low is a break.
            S_STOP: begin
               if (tick) begin
                  if (r_tick_cnt == C_STOP) begin
                     r_rx_data      <= r_shift;
                     r_rx_done      <= 1'b1;
                     r_frame_error  <= ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                     r_parity_error <= (^r_shift) ^ r_par_bit;
`endif
                     r_tick_cnt     <= '0;
                     r_state        <= r_rx_s ? S_IDLE : S_BREAK;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
            end
            S_BREAK: begin
               if (r_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_data      = r_rx_data;
   assign rx_done      = r_rx_done;
   assign frame_error  = r_frame_error;
`ifdef UART_RX_PARITY_EN
   assign parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames, hand-written glitch/reset sequences and
// random frames checked against a byte-level reference model.
module tb_uart_rx;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLK  = 16 * TICK_DIV;

   logic       clock;
   logic       reset;
   logic       tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_error;
   logic       parity_error;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICKS(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
`ifdef UART_RX_PARITY_EN
      .parity_error(parity_error),
`endif
      .frame_error (frame_error)
   );

`ifndef UART_RX_PARITY_EN
   assign parity_error = 1'b0;
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      tick = 1'b0;
      forever begin
         for (int k = 0; k < TICK_DIV; k++) begin
            @(negedge clock);
            tick = (k == TICK_DIV - 1);
         end
      end
   end

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } rec_t;

   rec_t got_q[$];

   always @(negedge clock) begin
      if (rx_done) got_q.push_back('{d: rx_data, fe: frame_error, pe: parity_error});
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic line_bits(input logic b, input int nbits);
      rx = b;
      repeat (nbits * BIT_CLK) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                             input int brk, input int gap);
      line_bits(1'b0, 1);
      for (int i = 0; i < 8; i++) line_bits(d[i], 1);
`ifdef UART_RX_PARITY_EN
      line_bits(par, 1);
`else
      if (par) rx = 1'b1;
`endif
      line_bits(stop, 1);
      if (brk > 0) line_bits(1'b0, brk);
      if (gap > 0) line_bits(1'b1, gap);
   endtask

   task automatic expect_frame(input string nm, input logic [7:0] d, input logic fe, input logic pe);
      rec_t r;
      chk({nm, " strobes"}, got_q.size(), 1);
      if (got_q.size() > 0) begin
         r = got_q.pop_front();
         chk({nm, " data"}, r.d, d);
         chk({nm, " frame_error"}, r.fe, fe);
`ifdef UART_RX_PARITY_EN
         chk({nm, " parity_error"}, r.pe, pe);
`else
         if (pe) r.pe = 1'b0;
`endif
      end
      got_q.delete();
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       par;
      int         brk;
      int         gap;
      logic [7:0] exp_d;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;

   vec_t tbl[$];
   vec_t v;

   initial begin
      logic [7:0] rd;
      logic       rs;
      logic       rp;
      int         rg;

      rx    = 1'b1;
      reset = 1'b1;
      repeat (5) @(negedge clock);
      chk("reset rx_data", rx_data, 8'h00);
      chk("reset rx_done", rx_done, 1'b0);
      chk("reset frame_error", frame_error, 1'b0);
      reset = 1'b0;
      line_bits(1'b1, 2);

      tbl.push_back('{d: 8'h55, stop: 1, par: 0, brk: 0, gap: 1, exp_d: 8'h55, exp_fe: 0, exp_pe: 0});
      tbl.push_back('{d: 8'hA3, stop: 1, par: 0, brk: 0, gap: 0, exp_d: 8'hA3, exp_fe: 0, exp_pe: 0});
      tbl.push_back('{d: 8'h00, stop: 1, par: 0, brk: 0, gap: 0, exp_d: 8'h00, exp_fe: 0, exp_pe: 0});
      tbl.push_back('{d: 8'hFF, stop: 1, par: 0, brk: 0, gap: 1, exp_d: 8'hFF, exp_fe: 0, exp_pe: 0});
      tbl.push_back('{d: 8'h3C, stop: 0, par: 0, brk: 5, gap: 2, exp_d: 8'h3C, exp_fe: 1, exp_pe: 0});
      tbl.push_back('{d: 8'h81, stop: 1, par: 0, brk: 0, gap: 1, exp_d: 8'h81, exp_fe: 0, exp_pe: 0});
      tbl.push_back('{d: 8'h07, stop: 1, par: 1, brk: 0, gap: 1, exp_d: 8'h07, exp_fe: 0, exp_pe: 0});
      tbl.push_back('{d: 8'h07, stop: 1, par: 0, brk: 0, gap: 1, exp_d: 8'h07, exp_fe: 0, exp_pe: 1});
      tbl.push_back('{d: 8'h81, stop: 1, par: 0, brk: 0, gap: 1, exp_d: 8'h81, exp_fe: 0, exp_pe: 0});

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         send_frame(v.d, v.stop, v.par, v.brk, v.gap);
         expect_frame($sformatf("vec%0d", i), v.exp_d, v.exp_fe, v.exp_pe);
      end

      // Start glitch of 3 ticks must be rejected silently.
      rx = 1'b0;
      repeat (3 * TICK_DIV) @(negedge clock);
      line_bits(1'b1, 2);
      chk("glitch strobes", got_q.size(), 0);

      // Reset in the middle of data bit 4 aborts the frame and clears outputs.
      line_bits(1'b0, 1);
      for (int i = 0; i < 4; i++) line_bits(i[0], 1);
      rx = 1'b0;
      repeat (BIT_CLK / 2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midreset rx_data", rx_data, 8'h00);
      chk("midreset rx_done", rx_done, 1'b0);
      chk("midreset frame_error", frame_error, 1'b0);
      rx = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      line_bits(1'b1, 3);
      chk("midreset strobes", got_q.size(), 0);
      send_frame(8'h7E, 1'b1, 1'b0, 0, 1);
      expect_frame("after reset", 8'h7E, 1'b0, 1'b0);

      // Random frames; the model expects the byte back, fe from the stop bit, even parity.
      for (int i = 0; i < 24; i++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         rp = 1'($urandom);
         rg = rs ? int'($urandom_range(0, 1)) : 1;
         send_frame(rd, rs, rp, 0, rg);
         expect_frame($sformatf("rand%0d", i), rd, ~rs, (^rd) ^ rp);
      end

      line_bits(1'b1, 1);
      chk("final strobes", got_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
